// File: rtl/uxa_ps2_pkg.sv
// uxa_ps2_pkg: shared definitions for the PS/2 receive queue.
//   - rxq_state_e    : control FSM encodings (IDLE, CLEAR, HOLD)
//   - DEFAULT_*      : default FIFO depth and idle-timeout length
package uxa_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2
  } rxq_state_e;

  localparam int unsigned DEFAULT_DEPTH_LOG2     = 4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/uxa_ps2_fifo.sv
// uxa_ps2_fifo: synchronous FIFO, 2**DEPTH_LOG2 entries of W bits.
// Ports:
//   sys_clk_i, reset_i (async, active-low)
//   push_i / wdata_i : write; ignored when full unless a pop is accepted too
//   pop_i            : remove head entry; ignored when empty
//   rdata_o          : head entry, combinational from mem[rd_ptr]
//   empty_o, full_o, count_o : occupancy status
module uxa_ps2_fifo
  import uxa_ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int unsigned W          = 8
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [W-1:0]          wdata_i,
  input  logic                  pop_i,
  output logic [W-1:0]          rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned              DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]      DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]      CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0]    PTR_ONE   = DEPTH_LOG2'(1);

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == DEPTH_CNT);
  assign count_o = cnt;
  assign rdata_o = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata_i;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uxa_ps2_rxq.sv
// uxa_ps2_rxq: PS/2 receive queue behind the deserializing shift register.
// Captures each framed byte once into a FIFO, pulses the shift register clear
// afterwards, and offers a pop-style read port with a sticky overrun flag.
// Ports:
//   sys_clk_i, reset_i (async, active-low)
//   ps2_c_i    : synchronized PS/2 clock, used only for the idle timeout
//   d_i, frame_i : byte and framing-valid level from the shift register
//   shf_clr_o  : one-cycle clear pulse to the shift register
//   q_o, pop_i, empty_o, full_o, count_o : FIFO read port and status
//   overrun_o, ovr_clr_i : sticky overrun flag and its clear
// Build option: define UXA_PS2_RXQ_TIMEOUT_EN to include the idle timeout,
// which clears a stale partial frame after TIMEOUT_CYCLES of PS/2 clock idle.
//
// Handshake: a frame is taken on the first edge frame_i is seen high in IDLE;
// pop_i removes q_o on the edge it is sampled high and is ignored when empty.
module uxa_ps2_rxq
  import uxa_ps2_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = DEFAULT_DEPTH_LOG2,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  sys_clk_i,
  input  logic                  reset_i,
  input  logic                  ps2_c_i,
  input  logic [7:0]            d_i,
  input  logic                  frame_i,
  output logic                  shf_clr_o,
  output logic [7:0]            q_o,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overrun_o,
  input  logic                  ovr_clr_i
);

  rxq_state_e state_q;
  rxq_state_e state_d;
  logic       fifo_push;
  logic       ovr_set;
  logic       tmo_fire;

  uxa_ps2_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .W          (8)
  ) u_fifo (
    .sys_clk_i (sys_clk_i),
    .reset_i   (reset_i),
    .push_i    (fifo_push),
    .wdata_i   (d_i),
    .pop_i     (pop_i),
    .rdata_o   (q_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o)
  );

  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture only in IDLE; HOLD waits out the rest of the frame level so a
  // long frame_i high is never taken twice.
  always_comb begin
    state_d   = state_q;
    fifo_push = 1'b0;
    ovr_set   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_i) begin
          if (!full_o || pop_i) begin
            fifo_push = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
          state_d = ST_CLEAR;
        end else if (tmo_fire) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_HOLD;
      ST_HOLD: begin
        if (!frame_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign shf_clr_o = (state_q == ST_CLEAR);

  // Set beats clear when both happen on the same edge.
  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      overrun_o <= 1'b0;
    end else if (ovr_set) begin
      overrun_o <= 1'b1;
    end else if (ovr_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

`ifdef UXA_PS2_RXQ_TIMEOUT_EN
  localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_cnt;
  logic          ps2_c_q;

  // Saturating at TIMEOUT_CYCLES means the fire value is passed only once
  // per idle period.
  always_ff @(posedge sys_clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tmo_cnt <= '0;
      ps2_c_q <= 1'b0;
    end else begin
      ps2_c_q <= ps2_c_i;
      if (ps2_c_i != ps2_c_q) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
    end
  end

  assign tmo_fire = (tmo_cnt == TMO_FIRE) && ps2_c_i && (state_q == ST_IDLE);
`else
  logic unused_tmo;
  assign unused_tmo = ^{ps2_c_i, TIMEOUT_CYCLES[0]};
  assign tmo_fire   = 1'b0;
`endif

endmodule

// File: tb/tb_uxa_ps2_rxq.sv
module tb_uxa_ps2_rxq;

  localparam int unsigned DL2 = 4;
  localparam int unsigned TMO = 20;

  // ---------------- clock / reset ----------------
  logic             sys_clk_i = 1'b0;
  logic             reset_i;
  logic             ps2_c_i;
  logic [7:0]       d_i;
  logic             frame_i;
  logic             shf_clr_o;
  logic [7:0]       q_o;
  logic             pop_i;
  logic             empty_o;
  logic             full_o;
  logic [DL2:0]     count_o;
  logic             overrun_o;
  logic             ovr_clr_i;

  always #5 sys_clk_i = ~sys_clk_i;

  uxa_ps2_rxq #(
    .DEPTH_LOG2     (DL2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk_i (sys_clk_i),
    .reset_i   (reset_i),
    .ps2_c_i   (ps2_c_i),
    .d_i       (d_i),
    .frame_i   (frame_i),
    .shf_clr_o (shf_clr_o),
    .q_o       (q_o),
    .pop_i     (pop_i),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o),
    .overrun_o (overrun_o),
    .ovr_clr_i (ovr_clr_i)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_ovr;
  int         passed = 0;
  int         total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"}, 32'(count_o), 32'(exp_q.size()));
    chk({tag, " empty"}, 32'(empty_o), 32'(exp_q.size() == 0));
    chk({tag, " full"},  32'(full_o),  32'(exp_q.size() == 16));
    chk({tag, " ovr"},   32'(overrun_o), 32'(exp_ovr));
    if (exp_q.size() > 0) chk({tag, " q"}, 32'(q_o), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk_i);
    #1;
  endtask

  // One frame: frame_i high for one edge, then low through CLEAR and HOLD.
  task automatic send_frame(input logic [7:0] d, input logic pop, input logic clr, input string tag);
    logic set;
    set = 1'b0;
    if (exp_q.size() < 16 || pop) begin
      if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
      exp_q.push_back(d);
    end else begin
      set = 1'b1;
    end
    if (set) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
    frame_i = 1'b1; d_i = d; pop_i = pop; ovr_clr_i = clr;
    step();
    chk({tag, " clr pulse"}, 32'(shf_clr_o), 32'd1);
    check_state(tag);
    frame_i = 1'b0; pop_i = 1'b0; ovr_clr_i = 1'b0;
    step();
    step();
  endtask

  task automatic pop_one(input string tag);
    chk({tag, " head"}, 32'(q_o), 32'(exp_q[0]));
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    void'(exp_q.pop_front());
    check_state(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       frame;
    logic [7:0] d;
    logic       pop;
    logic [7:0] eq;
    logic       ee;
    logic [4:0] ecnt;
    logic       eclr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int pulses;
    int pulse_at;
    logic [7:0] last;

    reset_i = 1'b0; ps2_c_i = 1'b0; d_i = '0; frame_i = 1'b0;
    pop_i = 1'b0; ovr_clr_i = 1'b0; exp_ovr = 1'b0;
    #1;
    chk("reset clr", 32'(shf_clr_o), 32'd0);
    chk("reset q", 32'(q_o), 32'h00);
    check_state("reset");
    step();
    step();
    reset_i = 1'b1;
    step();

    // Single frame held 5 cycles, then a push coinciding with a pop, then drain.
    //          frame d      pop   eq     ee    cnt   clr
    vecs[0]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b1};
    vecs[1]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[2]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[3]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[4]  = '{1'b1, 8'h1C, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h1C, 1'b0, 5'd1, 1'b0};
    vecs[7]  = '{1'b1, 8'h2D, 1'b1, 8'h2D, 1'b0, 5'd1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h2D, 1'b0, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h2D, 1'b0, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 5'd0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 5'd0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      frame_i = vecs[i].frame; d_i = vecs[i].d; pop_i = vecs[i].pop;
      step();
      chk($sformatf("vec%0d q", i),     32'(q_o),       32'(vecs[i].eq));
      chk($sformatf("vec%0d empty", i), 32'(empty_o),   32'(vecs[i].ee));
      chk($sformatf("vec%0d count", i), 32'(count_o),   32'(vecs[i].ecnt));
      chk($sformatf("vec%0d clr", i),   32'(shf_clr_o), 32'(vecs[i].eclr));
      chk($sformatf("vec%0d ovr", i),   32'(overrun_o), 32'd0);
    end
    frame_i = 1'b0; pop_i = 1'b0;

    // Burst of 17 frames, last one dropped.
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b0, $sformatf("burst%0d", i));
    chk("burst full", 32'(full_o), 32'd1);
    chk("burst ovr", 32'(overrun_o), 32'd1);

    // Overrun clear, then clear colliding with a new drop.
    ovr_clr_i = 1'b1;
    step();
    ovr_clr_i = 1'b0;
    exp_ovr = 1'b0;
    check_state("ovr clr");
    send_frame(8'h55, 1'b0, 1'b1, "drop+clr");
    chk("drop+clr ovr held", 32'(overrun_o), 32'd1);
    ovr_clr_i = 1'b1;
    step();
    ovr_clr_i = 1'b0;
    exp_ovr = 1'b0;
    check_state("ovr clr2");

    // Drain 00..0F in order.
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d value", i), 32'(q_o), i);
      pop_one($sformatf("drain%0d", i));
    end
    chk("drained empty", 32'(empty_o), 32'd1);

    // Refill, then a frame that coincides with a pop at full.
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b0, 1'b0, $sformatf("refill%0d", i));
    send_frame(8'hAA, 1'b1, 1'b0, "full push+pop");
    chk("full push+pop count", 32'(count_o), 32'd16);
    chk("full push+pop ovr", 32'(overrun_o), 32'd0);
    last = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last = q_o;
      pop_one($sformatf("final%0d", i));
    end
    chk("last byte AA", 32'(last), 32'hAA);
    chk("final empty", 32'(empty_o), 32'd1);

    // Idle timeout: ps2_c_i high with no frame.
    pulses = 0; pulse_at = -1;
    ps2_c_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (shf_clr_o) begin pulses++; pulse_at = i; end
    end
`ifdef UXA_PS2_RXQ_TIMEOUT_EN
    chk("tmo pulses", 32'(pulses), 32'd1);
    chk("tmo pulse cycle", 32'(pulse_at), 32'd20);
`else
    chk("tmo pulses", 32'(pulses), 32'd0);
`endif
    check_state("tmo no push");

    // Toggle part-way: count restarts from the change.
    pulses = 0; pulse_at = -1;
    ps2_c_i = 1'b0;
    step();
    ps2_c_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (shf_clr_o) pulses++;
    end
    ps2_c_i = 1'b0;
    step();
    if (shf_clr_o) pulses++;
    ps2_c_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (shf_clr_o) begin pulses++; pulse_at = i; end
    end
`ifdef UXA_PS2_RXQ_TIMEOUT_EN
    chk("tmo restart pulses", 32'(pulses), 32'd1);
    chk("tmo restart cycle", 32'(pulse_at), 32'd20);
`else
    chk("tmo restart pulses", 32'(pulses), 32'd0);
`endif
    ps2_c_i = 1'b0;
    step();
    step();
    step();

    // Asynchronous reset while in HOLD with three bytes queued.
    send_frame(8'h71, 1'b0, 1'b0, "pre rst a");
    send_frame(8'h72, 1'b0, 1'b0, "pre rst b");
    frame_i = 1'b1; d_i = 8'h73;
    exp_q.push_back(8'h73);
    step();
    step();
    check_state("in hold");
    #2;
    reset_i = 1'b0;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    chk("async rst clr", 32'(shf_clr_o), 32'd0);
    chk("async rst q", 32'(q_o), 32'h00);
    check_state("async rst");
    frame_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    check_state("post rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
